// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous single-port memory between the
// instruction-fetch port and the load/store data port. Each requester uses a
// level request with a one-cycle acknowledge; simultaneous requests are
// granted round-robin so neither side starves.
module mem_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  // instruction-fetch port (read only)
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ack,
  // load/store data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_wmask,
  output logic [31:0]       d_rdata,
  output logic              d_ack,
  // memory side
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  // status
  output logic              busy
);

  localparam int unsigned CNT_W     = 2;
  // WAIT lasts MEM_LATENCY-1 cycles: load with MEM_LATENCY-2 and leave at zero
  localparam int unsigned WAIT_INIT = (MEM_LATENCY > 1) ? (MEM_LATENCY - 2) : 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CAPTURE,
    ST_RESP
  } state_t;

  state_t           state;
  logic             owner_d;      // 1 = data port owns the access in flight
  logic             acc_we;       // access in flight is a write
  logic             last_grant_d; // 1 = data port was granted most recently
  logic [CNT_W-1:0] wait_cnt;
  logic             grant_d_c;

  // Round-robin choice: data wins only if fetch is idle or fetch went last
  assign grant_d_c = d_req & (~if_req | ~last_grant_d);

  // Arbitration FSM with registered memory strobes, acks and read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      owner_d      <= 1'b0;
      acc_we       <= 1'b0;
      last_grant_d <= 1'b1;
      wait_cnt     <= '0;
      if_rdata     <= '0;
      if_ack       <= 1'b0;
      d_rdata      <= '0;
      d_ack        <= 1'b0;
      mem_en       <= 1'b0;
      mem_we       <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      busy         <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (if_req || d_req) begin
            state        <= ST_ISSUE;
            busy         <= 1'b1;
            mem_en       <= 1'b1;
            owner_d      <= grant_d_c;
            last_grant_d <= grant_d_c;
            if (grant_d_c) begin
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              mem_we    <= d_we ? d_wmask : 4'b0000;
              acc_we    <= d_we;
            end else begin
              mem_addr  <= if_addr;
              mem_we    <= 4'b0000;
              acc_we    <= 1'b0;
            end
          end
        end

        ST_ISSUE: begin
          mem_en <= 1'b0;
          mem_we <= 4'b0000;
          if (acc_we) begin
            // writes need no read data: acknowledge in the next cycle
            state  <= ST_RESP;
            d_ack  <= owner_d;
            if_ack <= ~owner_d;
          end else if (MEM_LATENCY == 1) begin
            state <= ST_CAPTURE;
          end else begin
            state    <= ST_WAIT;
            wait_cnt <= CNT_W'(WAIT_INIT);
          end
        end

        ST_WAIT: begin
          if (wait_cnt == '0) begin
            state <= ST_CAPTURE;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end

        ST_CAPTURE: begin
          state <= ST_RESP;
          if (owner_d) begin
            d_rdata <= mem_rdata;
            d_ack   <= 1'b1;
          end else begin
            if_rdata <= mem_rdata;
            if_ack   <= 1'b1;
          end
        end

        ST_RESP: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: bench for mem_arbiter. Instance a uses the default
// one-cycle memory, instance b a three-cycle memory with its own reset.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic rst_b;
  logic load;

  always #5 clk = ~clk;

  // ---------------- instance a: MEM_LATENCY = 1 ----------------
  logic          if_req, if_ack, d_req, d_we, d_ack, mem_en, busy;
  logic [AW-1:0] if_addr, d_addr, mem_addr;
  logic [31:0]   if_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;
  logic [3:0]    d_wmask, mem_we;

  mem_arbiter #(.ADDR_W(AW), .MEM_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wmask(d_wmask), .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  // ---------------- instance b: MEM_LATENCY = 3 ----------------
  logic          b_if_req, b_if_ack, b_d_req, b_d_we, b_d_ack, b_mem_en, b_busy;
  logic [AW-1:0] b_if_addr, b_d_addr, b_mem_addr;
  logic [31:0]   b_if_rdata, b_d_wdata, b_d_rdata, b_mem_wdata, b_mem_rdata;
  logic [3:0]    b_d_wmask, b_mem_we;

  mem_arbiter #(.ADDR_W(AW), .MEM_LATENCY(3)) dut_b (
    .clk(clk), .rst_n(rst_b),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ack(b_if_ack),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_wmask(b_d_wmask), .d_rdata(b_d_rdata), .d_ack(b_d_ack),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  // ---------------- memory models ----------------
  function automatic logic [31:0] init_a(input int i);
    if (i == 4)  return 32'h0050_0093;
    if (i == 16) return 32'h0000_0000;
    return 32'h1000_0000 | 32'(i * 4);
  endfunction

  function automatic logic [31:0] init_b(input int i);
    return 32'hCAFE_0000 | 32'(i);
  endfunction

  logic [31:0] mem_a [256];
  logic [31:0] rd_a;
  logic [31:0] mem_b [256];
  logic [31:0] rd_b0, rd_b1, rd_b2;

  // One-cycle byte-writable RAM for instance a
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) mem_a[i] <= init_a(i);
    end else if (mem_en) begin
      for (int i = 0; i < 4; i++)
        if (mem_we[i]) mem_a[mem_addr[9:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
      rd_a <= mem_a[mem_addr[9:2]];
    end
  end
  assign mem_rdata = rd_a;

  // Three-cycle RAM for instance b: read word then two pipeline stages
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) mem_b[i] <= init_b(i);
    end else if (b_mem_en) begin
      for (int i = 0; i < 4; i++)
        if (b_mem_we[i]) mem_b[b_mem_addr[9:2]][8*i +: 8] <= b_mem_wdata[8*i +: 8];
      rd_b0 <= mem_b[b_mem_addr[9:2]];
    end
    rd_b1 <= rd_b0;
    rd_b2 <= rd_b1;
  end
  assign b_mem_rdata = rd_b2;

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One arbitration scenario on instance a with its expected outcome
  typedef struct {
    bit          f;
    bit          d;
    logic [31:0] fa;
    bit          dwe;
    logic [31:0] da;
    logic [31:0] dwd;
    logic [3:0]  dm;
    int          ef_cyc;
    int          ed_cyc;
    logic [31:0] ef_data;
    logic [31:0] ed_data;
  } vec_t;

  // Reference model: word memory plus who was granted last
  logic [31:0] ref_mem [256];
  bit          last_data;

  // Predict grant order, ack cycles (cycle 0 = request seen) and read data
  task automatic predict(inout vec_t v);
    int  t;
    bit  fetch_first;
    int  idx;
    fetch_first = v.f && (!v.d || last_data);
    t = 0;
    v.ef_cyc = 0; v.ed_cyc = 0; v.ef_data = '0; v.ed_data = '0;
    if (fetch_first) begin
      v.ef_data = ref_mem[v.fa[9:2]];
      v.ef_cyc  = t + 3;
      t         = t + 4;
      last_data = 1'b0;
    end
    if (v.d) begin
      idx = int'(v.da[9:2]);
      if (v.dwe) begin
        for (int i = 0; i < 4; i++)
          if (v.dm[i]) ref_mem[idx][8*i +: 8] = v.dwd[8*i +: 8];
        v.ed_cyc = t + 2;
        t        = t + 3;
      end else begin
        v.ed_data = ref_mem[idx];
        v.ed_cyc  = t + 3;
        t         = t + 4;
      end
      last_data = 1'b1;
    end
    if (v.f && !fetch_first) begin
      v.ef_data = ref_mem[v.fa[9:2]];
      v.ef_cyc  = t + 3;
      last_data = 1'b0;
    end
  endtask

  // Apply one scenario to instance a starting in an IDLE cycle; returns in IDLE
  task automatic run_a(input vec_t v, input string tag);
    int          fc, dc, fn, dn, f_iss, d_iss, last;
    bit          both;
    logic [31:0] fr, dr, fiss_addr, diss_addr, diss_wd;
    logic        fiss_en, diss_en, busy_after;
    logic [3:0]  fiss_we, diss_we;
    fc = -1; dc = -1; fn = 0; dn = 0; both = 1'b0;
    fr = '0; dr = '0; fiss_addr = '0; diss_addr = '0; diss_wd = '0;
    fiss_en = 1'b0; diss_en = 1'b0; fiss_we = '0; diss_we = '0; busy_after = 1'b1;
    f_iss = v.ef_cyc - 2;
    d_iss = v.ed_cyc - (v.dwe ? 1 : 2);
    last  = (v.ef_cyc > v.ed_cyc) ? v.ef_cyc : v.ed_cyc;
    if_req  = v.f;
    if_addr = v.fa;
    d_req   = v.d;
    d_we    = v.dwe;
    d_addr  = v.da;
    d_wdata = v.dwd;
    d_wmask = v.dm;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (v.f && c == f_iss) begin fiss_en = mem_en; fiss_we = mem_we; fiss_addr = mem_addr; end
      if (v.d && c == d_iss) begin
        diss_en = mem_en; diss_we = mem_we; diss_addr = mem_addr; diss_wd = mem_wdata;
      end
      if (c == last + 1) busy_after = busy;
      if (if_ack && d_ack) both = 1'b1;
      if (if_ack) begin
        fn++;
        if (fc < 0) begin fc = c; fr = if_rdata; end
        if_req = 1'b0;
      end
      if (d_ack) begin
        dn++;
        if (dc < 0) begin dc = c; dr = d_rdata; end
        d_req = 1'b0;
      end
    end
    if (v.f) begin
      chk({tag, " if_ack_cycle"}, 32'(fc), 32'(v.ef_cyc));
      chk({tag, " if_rdata"}, fr, v.ef_data);
      chk({tag, " if_ack_count"}, 32'(fn), 32'd1);
      chk({tag, " if_issue_en"}, 32'(fiss_en), 32'd1);
      chk({tag, " if_issue_we"}, 32'(fiss_we), 32'd0);
      chk({tag, " if_issue_addr"}, fiss_addr, v.fa);
    end else begin
      chk({tag, " if_ack_count"}, 32'(fn), 32'd0);
    end
    if (v.d) begin
      chk({tag, " d_ack_cycle"}, 32'(dc), 32'(v.ed_cyc));
      if (!v.dwe) chk({tag, " d_rdata"}, dr, v.ed_data);
      chk({tag, " d_ack_count"}, 32'(dn), 32'd1);
      chk({tag, " d_issue_en"}, 32'(diss_en), 32'd1);
      chk({tag, " d_issue_we"}, 32'(diss_we), v.dwe ? 32'(v.dm) : 32'd0);
      chk({tag, " d_issue_addr"}, diss_addr, v.da);
      if (v.dwe) chk({tag, " d_issue_wdata"}, diss_wd, v.dwd);
    end else begin
      chk({tag, " d_ack_count"}, 32'(dn), 32'd0);
    end
    chk({tag, " both_acks"}, 32'(both), 32'd0);
    chk({tag, " busy_after"}, 32'(busy_after), 32'd0);
  endtask

  vec_t tbl [9];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v, m;
    int   fc, dc, spur;
    logic [31:0] fr, dr;

    load = 1'b1; rst_n = 1'b0; rst_b = 1'b0;
    if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_wmask = '0;
    b_if_req = 0; b_if_addr = '0; b_d_req = 0; b_d_we = 0; b_d_addr = '0; b_d_wdata = '0; b_d_wmask = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_a(i);
    last_data = 1'b1;

    //       f  d  fa          dwe da          dwd           dm       efc edc ef_data        ed_data
    tbl[0] = '{1, 1, 32'h10, 0, 32'h20, 32'h0,        4'b0000, 3, 7, 32'h0050_0093, 32'h1000_0020};
    tbl[1] = '{1, 0, 32'h10, 0, 32'h0,  32'h0,        4'b0000, 3, 0, 32'h0050_0093, 32'h0};
    tbl[2] = '{0, 1, 32'h0,  1, 32'h40, 32'hDEADBEEF, 4'b0011, 0, 2, 32'h0,         32'h0};
    tbl[3] = '{0, 1, 32'h0,  0, 32'h40, 32'h0,        4'b0000, 0, 3, 32'h0,         32'h0000_BEEF};
    tbl[4] = '{1, 1, 32'h40, 1, 32'h40, 32'h12345678, 4'b1100, 3, 6, 32'h0000_BEEF, 32'h0};
    tbl[5] = '{0, 1, 32'h0,  1, 32'h40, 32'hFFFFFFFF, 4'b0000, 0, 2, 32'h0,         32'h0};
    tbl[6] = '{1, 0, 32'h40, 0, 32'h0,  32'h0,        4'b0000, 3, 0, 32'h1234_BEEF, 32'h0};
    tbl[7] = '{1, 1, 32'h40, 1, 32'h40, 32'hAABBCCDD, 4'b1111, 6, 2, 32'hAABB_CCDD, 32'h0};
    tbl[8] = '{1, 1, 32'h20, 0, 32'h10, 32'h0,        4'b0000, 7, 3, 32'h1000_0020, 32'h0050_0093};

    repeat (3) @(negedge clk);
    load = 1'b0;
    // reset values
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst acks", 32'({if_ack, d_ack}), 32'd0);
    chk("rst mem_en_we", 32'({mem_en, mem_we}), 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst mem_wdata", mem_wdata, 32'd0);
    chk("rst if_rdata", if_rdata, 32'd0);
    chk("rst d_rdata", d_rdata, 32'd0);
    rst_n = 1'b1; rst_b = 1'b1;
    @(negedge clk);

    // directed table on instance a
    for (int i = 0; i < 9; i++) begin
      m = tbl[i];
      predict(m);
      run_a(tbl[i], $sformatf("tbl%0d", i));
    end

    // randomized scenarios against the reference model
    for (int i = 0; i < 40; i++) begin
      v.f   = 1'($urandom_range(0, 1));
      v.d   = 1'($urandom_range(0, 1));
      if (!v.f && !v.d) v.f = 1'b1;
      v.fa  = 32'h100 + (32'($urandom_range(0, 7)) << 2);
      v.da  = 32'h100 + (32'($urandom_range(0, 7)) << 2);
      v.dwe = 1'($urandom_range(0, 1));
      v.dwd = $urandom;
      v.dm  = 4'($urandom);
      predict(v);
      run_a(v, $sformatf("rnd%0d", i));
    end

    // instance b: latency-3 data read, address changes ignored while busy
    b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 32'h24;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) chk("b en_c1", 32'(b_mem_en), 32'd1);
      if (c <= 4) begin
        chk($sformatf("b addr_hold_c%0d", c), b_mem_addr, 32'h24);
        chk($sformatf("b no_ack_c%0d", c), 32'(b_d_ack), 32'd0);
        b_d_addr = 32'h80 + 32'(c * 4);
      end
      if (c == 5) begin
        chk("b d_ack_c5", 32'(b_d_ack), 32'd1);
        chk("b d_rdata", b_d_rdata, 32'hCAFE_0009);
        b_d_req = 1'b0;
      end
      if (c == 6) begin
        chk("b busy_c6", 32'(b_busy), 32'd0);
        chk("b d_ack_c6", 32'(b_d_ack), 32'd0);
      end
    end

    // instance b: reset during WAIT abandons the fetch without an ack
    b_if_req = 1'b1; b_if_addr = 32'h28;
    @(negedge clk);
    @(negedge clk);
    chk("b wait_busy", 32'(b_busy), 32'd1);
    rst_b = 1'b0;
    #1;
    chk("b rst_busy", 32'(b_busy), 32'd0);
    chk("b rst_mem", 32'({b_mem_en, b_mem_we}), 32'd0);
    chk("b rst_addr", b_mem_addr, 32'd0);
    chk("b rst_rdata", b_d_rdata | b_if_rdata, 32'd0);
    b_if_req = 1'b0;
    spur = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (b_if_ack || b_d_ack) spur++;
    end
    rst_b = 1'b1;
    b_if_req = 1'b1; b_if_addr = 32'h28;
    b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 32'h2C;
    fc = -1; dc = -1; fr = '0; dr = '0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (b_if_ack && b_d_ack) spur++;
      if (b_if_ack) begin if (fc < 0) begin fc = c; fr = b_if_rdata; end else spur++; b_if_req = 1'b0; end
      if (b_d_ack) begin if (dc < 0) begin dc = c; dr = b_d_rdata; end else spur++; b_d_req = 1'b0; end
    end
    chk("b spurious_acks", 32'(spur), 32'd0);
    chk("b post_rst if_cycle", 32'(fc), 32'd5);
    chk("b post_rst if_rdata", fr, 32'hCAFE_000A);
    chk("b post_rst d_cycle", 32'(dc), 32'd11);
    chk("b post_rst d_rdata", dr, 32'hCAFE_000B);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
